// File: rtl/phy_bus_arbiter_if.sv
// Bus bundle for phy_bus_arbiter: two requester-side TileLink-style ports
// (if_*, ma_*) plus the shared downstream port (m_*).
// The slave modport is the arbiter's view. The master modport is the
// surrounding requesters and interconnect.
interface phy_bus_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic            if_request;
    logic            if_grant;
    logic            if_a_valid;
    logic            if_a_ready;
    logic [2:0]      if_a_opcode;
    logic [AW-1:0]   if_a_address;
    logic [DW-1:0]   if_a_data;
    logic [DW/8-1:0] if_a_mask;
    logic            if_d_valid;
    logic            if_d_ready;
    logic [DW-1:0]   if_d_data;
    logic            if_d_error;

    logic            ma_request;
    logic            ma_grant;
    logic            ma_a_valid;
    logic            ma_a_ready;
    logic [2:0]      ma_a_opcode;
    logic [AW-1:0]   ma_a_address;
    logic [DW-1:0]   ma_a_data;
    logic [DW/8-1:0] ma_a_mask;
    logic            ma_d_valid;
    logic            ma_d_ready;
    logic [DW-1:0]   ma_d_data;
    logic            ma_d_error;

    logic            m_a_valid;
    logic            m_a_ready;
    logic [2:0]      m_a_opcode;
    logic [AW-1:0]   m_a_address;
    logic [DW-1:0]   m_a_data;
    logic [DW/8-1:0] m_a_mask;
    logic            m_d_valid;
    logic            m_d_ready;
    logic [DW-1:0]   m_d_data;
    logic            m_d_error;

    modport slave (
        input  if_request, if_a_valid, if_a_opcode, if_a_address, if_a_data, if_a_mask, if_d_ready,
        output if_grant, if_a_ready, if_d_valid, if_d_data, if_d_error,
        input  ma_request, ma_a_valid, ma_a_opcode, ma_a_address, ma_a_data, ma_a_mask, ma_d_ready,
        output ma_grant, ma_a_ready, ma_d_valid, ma_d_data, ma_d_error,
        output m_a_valid, m_a_opcode, m_a_address, m_a_data, m_a_mask, m_d_ready,
        input  m_a_ready, m_d_valid, m_d_data, m_d_error
    );

    modport master (
        output if_request, if_a_valid, if_a_opcode, if_a_address, if_a_data, if_a_mask, if_d_ready,
        input  if_grant, if_a_ready, if_d_valid, if_d_data, if_d_error,
        output ma_request, ma_a_valid, ma_a_opcode, ma_a_address, ma_a_data, ma_a_mask, ma_d_ready,
        input  ma_grant, ma_a_ready, ma_d_valid, ma_d_data, ma_d_error,
        input  m_a_valid, m_a_opcode, m_a_address, m_a_data, m_a_mask, m_d_ready,
        output m_a_ready, m_d_valid, m_d_data, m_d_error
    );
endinterface

// File: rtl/phy_bus_arbiter.sv
// phy_bus_arbiter: shares one physical memory port between the fetch (IF)
// and memory-access (MA) requesters. Ownership lasts for a whole request
// window. At most one A transaction is outstanding, and its D response is
// routed back to the owner.
// Compile-time option: PHY_ARB_ROUND_ROBIN_EN selects round-robin tie-break.
// When it is undefined, MA wins every tie.
module phy_bus_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    phy_bus_arbiter_if.slave    bus,
    output logic                arb_err
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_IF = 2'd1,
        ST_OWN_MA = 2'd2
    } state_t;

    localparam logic LAST_IF = 1'b0;
    localparam logic LAST_MA = 1'b1;

    state_t state_r, state_nxt_s;
    logic   pending_r, pending_nxt_s;
    logic   last_r, last_nxt_s;
    logic   arb_err_r, arb_err_nxt_s;
    logic   if_grant_r, ma_grant_r;
    logic   tie_to_ma_s;

    assign bus.if_grant = if_grant_r;
    assign bus.ma_grant = ma_grant_r;
    assign arb_err      = arb_err_r;

    // Tie-break: round-robin away from the last owner, or fixed MA priority.
    always_comb begin
`ifdef PHY_ARB_ROUND_ROBIN_EN
        tie_to_ma_s = (last_r == LAST_IF);
`else
        tie_to_ma_s = 1'b1;
`endif
    end

    // Next-state logic. Ownership is released only after the in-flight
    // transaction completes.
    always_comb begin
        state_nxt_s = state_r;
        last_nxt_s  = last_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.if_request && bus.ma_request) begin
                    state_nxt_s = tie_to_ma_s ? ST_OWN_MA : ST_OWN_IF;
                end else if (bus.if_request) begin
                    state_nxt_s = ST_OWN_IF;
                end else if (bus.ma_request) begin
                    state_nxt_s = ST_OWN_MA;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_OWN_IF: begin
                if (!bus.if_request && !pending_r) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = LAST_IF;
                end else begin
                    state_nxt_s = ST_OWN_IF;
                end
            end
            ST_OWN_MA: begin
                if (!bus.ma_request && !pending_r) begin
                    state_nxt_s = ST_IDLE;
                    last_nxt_s  = LAST_MA;
                end else begin
                    state_nxt_s = ST_OWN_MA;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // A-channel forwarding from the owner. A new A is blocked while one is outstanding.
    always_comb begin
        bus.m_a_valid   = 1'b0;
        bus.m_a_opcode  = 3'd0;
        bus.m_a_address = {AW{1'b0}};
        bus.m_a_data    = {DW{1'b0}};
        bus.m_a_mask    = {(DW/8){1'b0}};
        bus.if_a_ready  = 1'b0;
        bus.ma_a_ready  = 1'b0;
        case (state_r)
            ST_OWN_IF: begin
                bus.m_a_valid   = bus.if_a_valid & ~pending_r;
                bus.m_a_opcode  = bus.if_a_opcode;
                bus.m_a_address = bus.if_a_address;
                bus.m_a_data    = bus.if_a_data;
                bus.m_a_mask    = bus.if_a_mask;
                bus.if_a_ready  = bus.m_a_ready & ~pending_r;
            end
            ST_OWN_MA: begin
                bus.m_a_valid   = bus.ma_a_valid & ~pending_r;
                bus.m_a_opcode  = bus.ma_a_opcode;
                bus.m_a_address = bus.ma_a_address;
                bus.m_a_data    = bus.ma_a_data;
                bus.m_a_mask    = bus.ma_a_mask;
                bus.ma_a_ready  = bus.m_a_ready & ~pending_r;
            end
            default: begin
                bus.m_a_valid = 1'b0;
            end
        endcase
    end

    // D-channel routing to the owner. Beats with nothing outstanding are drained.
    always_comb begin
        bus.m_d_ready  = 1'b0;
        bus.if_d_valid = 1'b0;
        bus.if_d_data  = {DW{1'b0}};
        bus.if_d_error = 1'b0;
        bus.ma_d_valid = 1'b0;
        bus.ma_d_data  = {DW{1'b0}};
        bus.ma_d_error = 1'b0;
        if (pending_r) begin
            case (state_r)
                ST_OWN_IF: begin
                    bus.if_d_valid = bus.m_d_valid;
                    bus.if_d_data  = bus.m_d_data;
                    bus.if_d_error = bus.m_d_error;
                    bus.m_d_ready  = bus.if_d_ready;
                end
                ST_OWN_MA: begin
                    bus.ma_d_valid = bus.m_d_valid;
                    bus.ma_d_data  = bus.m_d_data;
                    bus.ma_d_error = bus.m_d_error;
                    bus.m_d_ready  = bus.ma_d_ready;
                end
                default: begin
                    bus.m_d_ready = bus.m_d_valid;
                end
            endcase
        end else begin
            bus.m_d_ready = bus.m_d_valid;
        end
    end

    // Outstanding-transaction flag and sticky error for unexpected D beats.
    always_comb begin
        if (bus.m_a_valid && bus.m_a_ready) begin
            pending_nxt_s = 1'b1;
        end else if (pending_r && bus.m_d_valid && bus.m_d_ready) begin
            pending_nxt_s = 1'b0;
        end else begin
            pending_nxt_s = pending_r;
        end
        arb_err_nxt_s = arb_err_r | (bus.m_d_valid & ~pending_r);
    end

    // State, bookkeeping and registered grant/error outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            pending_r  <= 1'b0;
            last_r     <= LAST_IF;
            arb_err_r  <= 1'b0;
            if_grant_r <= 1'b0;
            ma_grant_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pending_r  <= pending_nxt_s;
            last_r     <= last_nxt_s;
            arb_err_r  <= arb_err_nxt_s;
            if_grant_r <= (state_nxt_s == ST_OWN_IF);
            ma_grant_r <= (state_nxt_s == ST_OWN_MA);
        end
    end
endmodule

// File: tb/tb_phy_bus_arbiter.sv
// Directed testbench for phy_bus_arbiter. Expected tie order follows
// PHY_ARB_ROUND_ROBIN_EN in the same way as the design build.
module tb_phy_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic arb_err;
    int   vec  = 0;
    int   errs = 0;

    phy_bus_arbiter_if #(.AW(64), .DW(64)) bus ();

    phy_bus_arbiter #(.AW(64), .DW(64)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .arb_err (arb_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic who_ma, input logic v);
        if (who_ma) bus.ma_request = v; else bus.if_request = v;
    endtask

    task automatic set_a_valid(input logic who_ma, input logic v);
        if (who_ma) bus.ma_a_valid = v; else bus.if_a_valid = v;
    endtask

    task automatic clear_inputs();
        bus.if_request = 1'b0; bus.if_a_valid = 1'b0; bus.if_a_opcode = 3'd0;
        bus.if_a_address = 64'd0; bus.if_a_data = 64'd0; bus.if_a_mask = 8'd0; bus.if_d_ready = 1'b0;
        bus.ma_request = 1'b0; bus.ma_a_valid = 1'b0; bus.ma_a_opcode = 3'd0;
        bus.ma_a_address = 64'd0; bus.ma_a_data = 64'd0; bus.ma_a_mask = 8'd0; bus.ma_d_ready = 1'b0;
        bus.m_a_ready = 1'b0; bus.m_d_valid = 1'b0; bus.m_d_data = 64'd0; bus.m_d_error = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        vec++; if (bus.if_grant !== 1'b0) begin errs++; $display("FAIL reset_if_grant: got %b want 0", bus.if_grant); end
        vec++; if (bus.ma_grant !== 1'b0) begin errs++; $display("FAIL reset_ma_grant: got %b want 0", bus.ma_grant); end
        vec++; if (arb_err !== 1'b0) begin errs++; $display("FAIL reset_arb_err: got %b want 0", arb_err); end
        vec++; if ({bus.m_a_valid, bus.m_d_ready, bus.if_a_ready, bus.ma_a_ready} !== 4'b0000) begin
            errs++; $display("FAIL reset_valid_ready: got %b want 0000",
                             {bus.m_a_valid, bus.m_d_ready, bus.if_a_ready, bus.ma_a_ready}); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_if_read();
        bus.if_request = 1'b1;
        tick();
        vec++; if (bus.if_grant !== 1'b1) begin errs++; $display("FAIL if_grant_latency: got %b want 1", bus.if_grant); end
        vec++; if (bus.ma_grant !== 1'b0) begin errs++; $display("FAIL if_read_ma_grant: got %b want 0", bus.ma_grant); end
        bus.if_a_valid = 1'b1; bus.if_a_opcode = 3'd4; bus.if_a_address = 64'h8000_0000;
        bus.if_a_mask = 8'hFF; bus.m_a_ready = 1'b1;
        #1;
        vec++; if (bus.m_a_valid !== 1'b1) begin errs++; $display("FAIL if_a_fwd_valid: got %b want 1", bus.m_a_valid); end
        vec++; if (bus.m_a_address !== 64'h8000_0000) begin errs++; $display("FAIL if_a_fwd_addr: got %h want 80000000", bus.m_a_address); end
        vec++; if (bus.m_a_opcode !== 3'd4) begin errs++; $display("FAIL if_a_fwd_opcode: got %0d want 4", bus.m_a_opcode); end
        vec++; if (bus.if_a_ready !== 1'b1) begin errs++; $display("FAIL if_a_ready: got %b want 1", bus.if_a_ready); end
        tick();
        vec++; if ({bus.m_a_valid, bus.if_a_ready} !== 2'b00) begin
            errs++; $display("FAIL if_a_blocked_pending: got %b want 00", {bus.m_a_valid, bus.if_a_ready}); end
        bus.if_a_valid = 1'b0;
        bus.m_d_valid = 1'b1; bus.m_d_data = 64'hDEAD_BEEF; bus.if_d_ready = 1'b1;
        #1;
        vec++; if (bus.if_d_valid !== 1'b1) begin errs++; $display("FAIL if_d_valid: got %b want 1", bus.if_d_valid); end
        vec++; if (bus.if_d_data !== 64'hDEAD_BEEF) begin errs++; $display("FAIL if_d_data: got %h want deadbeef", bus.if_d_data); end
        vec++; if (bus.ma_d_valid !== 1'b0) begin errs++; $display("FAIL if_read_ma_d_valid: got %b want 0", bus.ma_d_valid); end
        vec++; if (bus.m_d_ready !== 1'b1) begin errs++; $display("FAIL if_m_d_ready: got %b want 1", bus.m_d_ready); end
        tick();
        bus.m_d_valid = 1'b0; bus.m_d_data = 64'd0; bus.if_a_valid = 1'b1;
        #1;
        vec++; if (bus.if_a_ready !== 1'b1) begin errs++; $display("FAIL if_pending_cleared: got %b want 1", bus.if_a_ready); end
        bus.if_a_valid = 1'b0; bus.if_request = 1'b0; bus.if_d_ready = 1'b0; bus.m_a_ready = 1'b0;
        tick();
        vec++; if (bus.if_grant !== 1'b0) begin errs++; $display("FAIL if_release: got %b want 0", bus.if_grant); end
        vec++; if (arb_err !== 1'b0) begin errs++; $display("FAIL if_read_arb_err: got %b want 0", arb_err); end
        tick();
    endtask

    task automatic test_tie_break();
        logic exp_ma [4];
`ifdef PHY_ARB_ROUND_ROBIN_EN
        exp_ma = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_ma = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        for (int i = 0; i < 4; i++) begin
            bus.if_request = 1'b1; bus.ma_request = 1'b1;
            tick();
            vec++; if (bus.ma_grant !== exp_ma[i] || bus.if_grant !== ~exp_ma[i]) begin
                errs++; $display("FAIL tie_order[%0d]: got ma=%b if=%b want ma=%b if=%b",
                                 i, bus.ma_grant, bus.if_grant, exp_ma[i], ~exp_ma[i]); end
            set_a_valid(exp_ma[i], 1'b1); bus.m_a_ready = 1'b1;
            tick();
            set_a_valid(exp_ma[i], 1'b0); bus.m_a_ready = 1'b0;
            bus.m_d_valid = 1'b1; bus.m_d_data = 64'h100 + 64'(i);
            bus.if_d_ready = 1'b1; bus.ma_d_ready = 1'b1;
            #1;
            vec++; if (bus.ma_d_valid !== exp_ma[i] || bus.if_d_valid !== ~exp_ma[i]) begin
                errs++; $display("FAIL tie_d_route[%0d]: got ma=%b if=%b want ma=%b if=%b",
                                 i, bus.ma_d_valid, bus.if_d_valid, exp_ma[i], ~exp_ma[i]); end
            tick();
            bus.m_d_valid = 1'b0; bus.if_d_ready = 1'b0; bus.ma_d_ready = 1'b0;
            bus.if_request = 1'b0; bus.ma_request = 1'b0;
            tick();
            vec++; if ({bus.ma_grant, bus.if_grant} !== 2'b00) begin
                errs++; $display("FAIL tie_release[%0d]: got %b want 00", i, {bus.ma_grant, bus.if_grant}); end
            tick();
        end
    endtask

    task automatic test_drop_while_pending();
        bus.ma_request = 1'b1;
        tick();
        bus.ma_a_valid = 1'b1; bus.m_a_ready = 1'b1;
        tick();
        bus.ma_a_valid = 1'b0; bus.m_a_ready = 1'b0;
        bus.ma_request = 1'b0; bus.if_request = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vec++; if ({bus.ma_grant, bus.if_grant} !== 2'b10) begin
                errs++; $display("FAIL drop_hold[%0d]: got %b want 10", i, {bus.ma_grant, bus.if_grant}); end
        end
        bus.m_d_valid = 1'b1; bus.m_d_data = 64'h5A5A; bus.ma_d_ready = 1'b1;
        #1;
        vec++; if (bus.ma_d_valid !== 1'b1) begin errs++; $display("FAIL drop_d_valid: got %b want 1", bus.ma_d_valid); end
        tick();
        bus.m_d_valid = 1'b0; bus.ma_d_ready = 1'b0;
        vec++; if ({bus.ma_grant, bus.if_grant} !== 2'b10) begin
            errs++; $display("FAIL drop_after_d: got %b want 10", {bus.ma_grant, bus.if_grant}); end
        tick();
        vec++; if ({bus.ma_grant, bus.if_grant} !== 2'b00) begin
            errs++; $display("FAIL drop_idle_gap: got %b want 00", {bus.ma_grant, bus.if_grant}); end
        tick();
        vec++; if ({bus.ma_grant, bus.if_grant} !== 2'b01) begin
            errs++; $display("FAIL drop_next_owner: got %b want 01", {bus.ma_grant, bus.if_grant}); end
        bus.if_request = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_pressure();
        bus.ma_request = 1'b1;
        tick();
        bus.ma_a_valid = 1'b1; bus.ma_a_address = 64'h40; bus.m_a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++; if ({bus.m_a_valid, bus.ma_a_ready} !== 2'b10) begin
                errs++; $display("FAIL bp_a_stall[%0d]: got %b want 10", i, {bus.m_a_valid, bus.ma_a_ready}); end
            tick();
        end
        bus.m_a_ready = 1'b1;
        #1;
        vec++; if (bus.ma_a_ready !== 1'b1) begin errs++; $display("FAIL bp_a_accept: got %b want 1", bus.ma_a_ready); end
        tick();
        vec++; if ({bus.m_a_valid, bus.ma_a_ready} !== 2'b00) begin
            errs++; $display("FAIL bp_second_a_blocked: got %b want 00", {bus.m_a_valid, bus.ma_a_ready}); end
        bus.m_d_valid = 1'b1; bus.m_d_data = 64'h1234; bus.m_d_error = 1'b1; bus.ma_d_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vec++; if ({bus.ma_d_valid, bus.m_d_ready, bus.m_a_valid} !== 3'b100) begin
                errs++; $display("FAIL bp_d_hold[%0d]: got %b want 100", i, {bus.ma_d_valid, bus.m_d_ready, bus.m_a_valid}); end
            tick();
        end
        bus.ma_d_ready = 1'b1;
        #1;
        vec++; if ({bus.m_d_ready, bus.ma_d_error} !== 2'b11 || bus.ma_d_data !== 64'h1234) begin
            errs++; $display("FAIL bp_d_accept: got rdy/err=%b data=%h want 11 data=1234",
                             {bus.m_d_ready, bus.ma_d_error}, bus.ma_d_data); end
        tick();
        bus.m_d_valid = 1'b0; bus.m_d_error = 1'b0; bus.ma_d_ready = 1'b0;
        #1;
        vec++; if (bus.m_a_valid !== 1'b1) begin errs++; $display("FAIL bp_second_a_released: got %b want 1", bus.m_a_valid); end
        bus.ma_a_valid = 1'b0; bus.m_a_ready = 1'b0; bus.ma_request = 1'b0;
        tick();
        tick();
        vec++; if (arb_err !== 1'b0) begin errs++; $display("FAIL bp_arb_err: got %b want 0", arb_err); end
    endtask

    task automatic test_spurious_d();
        bus.m_d_valid = 1'b1; bus.m_d_data = 64'hBAD;
        #1;
        vec++; if ({bus.m_d_ready, bus.if_d_valid, bus.ma_d_valid} !== 3'b100) begin
            errs++; $display("FAIL spur_drain: got %b want 100", {bus.m_d_ready, bus.if_d_valid, bus.ma_d_valid}); end
        tick();
        bus.m_d_valid = 1'b0;
        vec++; if (arb_err !== 1'b1) begin errs++; $display("FAIL spur_arb_err: got %b want 1", arb_err); end
        tick(); tick(); tick();
        vec++; if (arb_err !== 1'b1) begin errs++; $display("FAIL spur_sticky: got %b want 1", arb_err); end
    endtask

    task automatic test_reset_mid_txn();
        bus.if_request = 1'b1;
        tick();
        bus.if_a_valid = 1'b1; bus.m_a_ready = 1'b1;
        tick();
        bus.if_a_valid = 1'b0; bus.m_a_ready = 1'b0; bus.if_request = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vec++; if ({bus.if_grant, bus.ma_grant, arb_err} !== 3'b000) begin
            errs++; $display("FAIL rst_mid_state: got %b want 000", {bus.if_grant, bus.ma_grant, arb_err}); end
        bus.m_d_valid = 1'b1; bus.if_d_ready = 1'b0;
        #1;
        vec++; if ({bus.m_d_ready, bus.if_d_valid} !== 2'b10) begin
            errs++; $display("FAIL rst_mid_late_d: got %b want 10", {bus.m_d_ready, bus.if_d_valid}); end
        tick();
        bus.m_d_valid = 1'b0;
        vec++; if (arb_err !== 1'b1) begin errs++; $display("FAIL rst_mid_late_err: got %b want 1", arb_err); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_if_read();
        test_tie_break();
        test_drop_while_pending();
        test_back_pressure();
        test_spurious_d();
        test_reset_mid_txn();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
